// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- parametrised universal shift register with frame counter.
//
// Modes: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
// A frame counter tracks consecutive same-direction shifts and pulses
// frame_done for one cycle after every WIDTH-th shift, so the block can
// serve as PISO / SIPO / PIPO / SISO.
//
// Optional build macro: USR_ROTATE_EN
//   defined   -> shifts rotate (sr_in / sl_in ignored)
//   undefined -> serial inputs feed the vacated end bit
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode[1:0]  operation select
//   p_in       parallel load data
//   sr_in      serial input entering bit WIDTH-1 on shift right
//   sl_in      serial input entering bit 0 on shift left
//   p_out      register contents
//   sr_out     p_out[0]
//   sl_out     p_out[WIDTH-1]
//   shift_cnt  shifts completed in the current frame (0..WIDTH-1)
//   frame_done one-cycle pulse after a completed WIDTH-shift frame

// One storage bit: picks hold / right-neighbour / left-neighbour / load.
module usr_bit_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       hi,   // value arriving on a right shift
  input  logic       lo,   // value arriving on a left shift
  input  logic       ld,   // parallel load bit
  output logic       q
);
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else begin
      case (mode)
        2'b01:   q <= hi;
        2'b10:   q <= lo;
        2'b11:   q <= ld;
        default: q <= q;
      endcase
    end
  end
endmodule

module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         p_in,
  input  logic                     sr_in,
  input  logic                     sl_in,
  output logic [WIDTH-1:0]         p_out,
  output logic                     sr_out,
  output logic                     sl_out,
  output logic [$clog2(WIDTH)-1:0] shift_cnt,
  output logic                     frame_done
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {DIR_R = 1'b0, DIR_L = 1'b1} dir_e;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] hi_src, lo_src;
  logic             ser_r, ser_l;

  // Bits inserted at the vacated end of the register.
`ifdef USR_ROTATE_EN
  assign ser_r = q[0];
  assign ser_l = q[WIDTH-1];
`else
  assign ser_r = sr_in;
  assign ser_l = sl_in;
`endif

  // Datapath: one cell per bit, neighbours wired by generate.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    if (g == WIDTH-1) begin : g_top
      assign hi_src[g] = ser_r;
    end else begin : g_mid_hi
      assign hi_src[g] = q[g+1];
    end
    if (g == 0) begin : g_bot
      assign lo_src[g] = ser_l;
    end else begin : g_mid_lo
      assign lo_src[g] = q[g-1];
    end
    usr_bit_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .hi   (hi_src[g]),
      .lo   (lo_src[g]),
      .ld   (p_in[g]),
      .q    (q[g])
    );
  end

  assign p_out  = q;
  assign sr_out = q[0];
  assign sl_out = q[WIDTH-1];

  // Frame counter state. 'fresh' marks that no shift has happened since
  // the last load/reset, so the next shift adopts its own direction and
  // counts as a continuation rather than a direction change.
  dir_e          dir_q;
  logic          fresh_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  logic is_shift;
  dir_e shift_dir;
  logic last_shift;

  always_comb begin
    is_shift   = (mode == MODE_SHR) || (mode == MODE_SHL);
    shift_dir  = (mode == MODE_SHL) ? DIR_L : DIR_R;
    last_shift = (cnt_q == CW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= DIR_R;
      fresh_q <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (is_shift) begin
        fresh_q <= 1'b0;
        dir_q   <= shift_dir;
        if (fresh_q || (shift_dir == dir_q)) begin
          if (last_shift) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          // Direction reversal: this shift starts a new frame.
          cnt_q <= CW'(1);
        end
      end else if (mode == MODE_LOAD) begin
        cnt_q   <= '0;
        fresh_q <= 1'b1;
      end
      // MODE_HOLD keeps count, direction and fresh state.
    end
  end

  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
`ifdef USR_ROTATE_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif
  localparam int CW = $clog2(W);
  localparam logic [1:0] H = 2'b00, R = 2'b01, L = 2'b10, LD = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = H;
  logic [W-1:0]  p_in = '0;
  logic          sr_in = 1'b0, sl_in = 1'b0;
  logic [W-1:0]  p_out;
  logic          sr_out, sl_out;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .p_in(p_in), .sr_in(sr_in),
    .sl_in(sl_in), .p_out(p_out), .sr_out(sr_out), .sl_out(sl_out),
    .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  typedef struct {
    logic [W-1:0] p;
    int           cnt;
    logic         fd;
    string        tag;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input string tag,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s: got %0h required %0h", tag, name, act, req);
    end
  endtask

  // Driver: inputs set on the falling edge, expectation queued for the
  // following rising edge.
  task automatic step(input logic r, input logic [1:0] m,
                      input logic [W-1:0] pi, input logic sr, input logic sl,
                      input logic [W-1:0] ep, input int ec, input logic efd,
                      input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; mode = m; p_in = pi; sr_in = sr; sl_in = sl;
    x.p = ep; x.cnt = ec; x.fd = efd; x.tag = tag;
    sbq.push_back(x);
  endtask

  // Monitor: each rising edge presents a result; compare against the queue.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("p_out",      e.tag, 32'(p_out),      32'(e.p));
      chk("shift_cnt",  e.tag, 32'(shift_cnt),  32'(e.cnt));
      chk("frame_done", e.tag, 32'(frame_done), 32'(e.fd));
      chk("sr_out",     e.tag, 32'(sr_out),     32'(e.p[0]));
      chk("sl_out",     e.tag, 32'(sl_out),     32'(e.p[W-1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef USR_ROTATE_EN
    step(1, LD, 8'hFF, 0, 0, 8'h00, 0, 0, "rst");
    step(0, LD, 8'h81, 0, 0, 8'h81, 0, 0, "load81");
    step(0, R,  '0,    0, 0, 8'hC0, 1, 0, "rot1");
    step(0, R,  '0,    0, 0, 8'h60, 2, 0, "rot2");
    step(0, R,  '0,    1, 1, 8'h30, 3, 0, "rot3");
    step(0, R,  '0,    0, 0, 8'h18, 4, 0, "rot4");
    step(0, R,  '0,    0, 0, 8'h0C, 5, 0, "rot5");
    step(0, R,  '0,    0, 0, 8'h06, 6, 0, "rot6");
    step(0, R,  '0,    0, 0, 8'h03, 7, 0, "rot7");
    step(0, R,  '0,    0, 0, 8'h81, 0, 1, "rot8");
    step(0, L,  '0,    0, 0, 8'h03, 1, 0, "rotl");
    step(0, H,  '0,    0, 0, 8'h03, 1, 0, "hold");
`else
    // Reset overrides a load request.
    step(1, LD, 4'hF, 0, 0, 4'h0, 0, 0, "rst");
    // PISO: sr_out sequence 1,1,0,1.
    step(0, LD, 4'hB, 0, 0, 4'hB, 0, 0, "piso_ld");
    step(0, R,  4'h0, 0, 0, 4'h5, 1, 0, "piso1");
    step(0, R,  4'h0, 0, 0, 4'h2, 2, 0, "piso2");
    step(0, R,  4'h0, 0, 0, 4'h1, 3, 0, "piso3");
    step(0, R,  4'h0, 0, 0, 4'h0, 0, 1, "piso4");
    step(0, R,  4'h0, 0, 0, 4'h0, 1, 0, "piso5");
    // SIPO after reset: word complete with frame_done.
    step(1, H,  4'h0, 0, 0, 4'h0, 0, 0, "rst2");
    step(0, L,  4'h0, 0, 1, 4'h1, 1, 0, "sipo1");
    step(0, L,  4'h0, 0, 0, 4'h2, 2, 0, "sipo2");
    step(0, L,  4'h0, 0, 0, 4'h4, 3, 0, "sipo3");
    step(0, L,  4'h0, 0, 1, 4'h9, 0, 1, "sipo4");
    step(0, H,  4'h0, 0, 0, 4'h9, 0, 0, "hold1");
    // Hold stretches a frame; direction change restarts at 1.
    step(0, LD, 4'h6, 0, 0, 4'h6, 0, 0, "dir_ld");
    step(0, R,  4'h0, 1, 0, 4'hB, 1, 0, "dir_r1");
    step(0, R,  4'h0, 0, 0, 4'h5, 2, 0, "dir_r2");
    step(0, H,  4'h0, 0, 0, 4'h5, 2, 0, "dir_h");
    step(0, L,  4'h0, 0, 1, 4'hB, 1, 0, "dir_l1");
    step(0, L,  4'h0, 0, 0, 4'h6, 2, 0, "dir_l2");
    step(0, L,  4'h0, 0, 0, 4'hC, 3, 0, "dir_l3");
    step(0, L,  4'h0, 0, 1, 4'h9, 0, 1, "dir_l4");
    step(0, H,  4'h0, 0, 0, 4'h9, 0, 0, "hold2");
    // Mid-frame reset.
    step(0, R,  4'h0, 1, 0, 4'hC, 1, 0, "mid_r1");
    step(0, R,  4'h0, 1, 0, 4'hE, 2, 0, "mid_r2");
    step(1, R,  4'h0, 1, 0, 4'h0, 0, 0, "mid_rst");
    // Mid-frame load, then a fresh shift adopts the new direction.
    step(0, L,  4'h0, 0, 1, 4'h1, 1, 0, "mid_l1");
    step(0, L,  4'h0, 0, 1, 4'h3, 2, 0, "mid_l2");
    step(0, LD, 4'hA, 0, 0, 4'hA, 0, 0, "mid_ld");
    step(0, R,  4'h0, 0, 0, 4'h5, 1, 0, "post_ld");
`endif
    @(negedge clk);
    rst = 1'b0; mode = H;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the next-generation replacement for the fixed 4-bit parallel-in/parallel-out register. It supports hold, shift right, shift left and parallel load on one clock. A frame counter flags every completed WIDTH-bit serial frame, so the block can act as PISO, SIPO, PIPO or SISO in serialiser and deserialiser datapaths.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal range ≥ 2.

Ports (`CW` = $clog2(WIDTH)):
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `mode` in 2: operation select. 2'b00 hold, 2'b01 shift right, 2'b10 shift left, 2'b11 parallel load.
- `p_in` in WIDTH: parallel load data.
- `sr_in` in 1: serial input for shift right; enters bit WIDTH-1.
- `sl_in` in 1: serial input for shift left; enters bit 0.
- `p_out` out WIDTH: register contents.
- `sr_out` out 1: serial output for shift right; equals `p_out[0]`.
- `sl_out` out 1: serial output for shift left; equals `p_out[WIDTH-1]`.
- `shift_cnt` out CW: consecutive same-direction shifts in the current frame, range 0..WIDTH-1.
- `frame_done` out 1: one-cycle pulse marking a completed WIDTH-shift frame.

## Operation
- Reset (`rst`=1 at an edge): `p_out`=0, `shift_cnt`=0, `frame_done`=0, internal direction flag=right. `rst` overrides `mode` and abandons any partial frame.
- Hold (00): `p_out` and `shift_cnt` unchanged; `frame_done` deasserts.
- Shift right (01): `p_out` ← {`sr_in`, `p_out[WIDTH-1:1]`}.
- Shift left (10): `p_out` ← {`p_out[WIDTH-2:0]`, `sl_in`}.
- Load (11): `p_out` ← `p_in`; `shift_cnt` ← 0; direction flag unchanged; `frame_done` deasserts.
- Frame counter, evaluated on each shift:
  - Same direction as the flag, or first shift after load or reset:
    - if `shift_cnt` < WIDTH-1: `shift_cnt` increments.
    - if `shift_cnt` = WIDTH-1: `shift_cnt` wraps to 0 and `frame_done` ← 1.
  - Opposite direction to the flag: the direction flag flips and `shift_cnt` ← 1, so this shift counts as the first of a new frame and no `frame_done` is raised.
- "First shift after load" adopts the shift's direction without resetting the count a second time.
- `frame_done` is 1 only in the cycle after the completing shift. It deasserts on the next edge unless that edge completes another frame, which is impossible for WIDTH ≥ 2.
- `sr_out` and `sl_out` are combinational slices of `p_out`, not separate flops.

## Timing
- All state changes on the rising edge of `clk`; every output is registered or a direct slice of a register.
- Latency is one cycle for every mode: `p_out`, `shift_cnt` and `frame_done` reflect the operation sampled at edge N from just after edge N.
- Serialise (PISO): load, then WIDTH shifts. All WIDTH bits appear on `sr_out`/`sl_out` on the load edge and on the following WIDTH-1 shift edges. `frame_done` rises on the WIDTH-th shift edge.
- Deserialise (SIPO): after WIDTH consecutive shifts, `p_out` holds the full word in the same cycle that `frame_done` is high.
- Holds inside a frame stretch it without losing the count.
- `mode` and the serial inputs have no handshake; they are sampled every edge.

## Configuration
- `USR_ROTATE_EN`:
  - Defined: shifts rotate. Shift right inserts `p_out[0]` at bit WIDTH-1; shift left inserts `p_out[WIDTH-1]` at bit 0. `sr_in` and `sl_in` are ignored, and frame counting is unchanged.
  - Undefined: serial inputs are used as specified in Operation, and no rotate logic is built.

## Test plan
Run at WIDTH=4 unless stated.
- Reset: `rst`=1 with `mode`=11, `p_in`=4'hF → after the edge `p_out`=4'h0, `shift_cnt`=0, `frame_done`=0.
- PISO: load 4'b1011, then 4 right shifts with `sr_in`=0 → `sr_out` sequence 1,1,0,1; `p_out`=4'h0; `frame_done` high only after the 4th shift; `shift_cnt` 1,2,3,0.
- SIPO: 4 left shifts with `sl_in` = 1,0,0,1 → `p_out`=4'b1001 in the same cycle `frame_done`=1.
- Hold/direction change: right, right, hold, left → `shift_cnt` 1,2,2,1; no `frame_done`; a 4th consecutive left after 3 more lefts pulses `frame_done`.
- Mid-frame reset and load: 2 shifts, then `rst` → `shift_cnt`=0; repeat with load 4'hA instead → `p_out`=4'hA, `shift_cnt`=0.
- Rotate build (`USR_ROTATE_EN`), WIDTH=8: load 8'h81, 1 right shift with `sr_in`=0 → `p_out`=8'hC0; after 8 right shifts in total → `p_out`=8'h81 and `frame_done`=1.
